nes_joypad_scan_ctrl: RTL
=========================

Name: nes_joypad_scan_ctrl

Overview:
Scan sequencer and request arbiter for the two NES joypad ports. It generates the latch and clock pulse train and samples both serial data lines. It shares a single scan engine between two requesters: the periodic auto-poll timer and on-demand CPU poll requests. Captured button states go to a registered CPU read port; the block sits between the board joypad connectors and the CPU I/O decode.

Parameters:
CLK_DIV, 200, clk cycles per half-bit tick (8 us at 25 MHz); legal range >= 2
POLL_TICKS, 2083, ticks between auto-poll requests (~16.7 ms at default CLK_DIV)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
data_d  in  2  serial data from pad 1 [1] and pad 0 [0], active-low (0 = pressed)
latch_q  out  2  latch to both pads, identical bits, active-high
clk_q  out  2  shift clock to both pads, identical bits, idles high
auto_en  in  1  enables auto-poll timer
cpu_req  in  1  one-cycle CPU poll request
cpu_ack  out  1  one-cycle pulse: scan serving a CPU request completed
busy  out  1  high while a scan is in progress (LATCH or SHIFT state)
scan_done  out  1  one-cycle pulse at end of every scan
rs  in  1  CPU register select: 0 = pad 0, 1 = pad 1
to_cpu  out  8  registered pad state for the selected pad, 1 = pressed
irq  out  1  button-change interrupt (see Optional Feature)
irq_clr  in  1  clears irq

Behaviour:
- Reset (rst_n = 0 at posedge clk): state IDLE; latch_q = 00; clk_q = 11; cpu_ack, busy, scan_done, irq = 0; pads and to_cpu = 00h; prescaler, period counter and both pending flags = 0. Reset mid-scan aborts the scan without updating pads.
- Prescaler: free-running 0..CLK_DIV-1; tick = (count == CLK_DIV-1). Runs in every state.
- Period counter: counts ticks while auto_en = 1. At POLL_TICKS-1 it wraps to 0 and sets auto_pend. auto_en = 0 holds the counter at 0.
- cpu_req = 1 sets cpu_pend. A request during a scan stays pending and triggers one further scan. Repeated requests before service merge into one.
- States:
  - IDLE: latch_q = 00, clk_q = 11. On a tick with auto_pend | cpu_pend: go to LATCH, bit_idx = 0, capture served_cpu = cpu_pend, clear both pend flags. A request arriving in that same cycle is kept pending.
  - LATCH: latch_q = 11 for 2 ticks, clk_q = 11. Then go to SHIFT_LO.
  - SHIFT_LO: clk_q = 00 for 1 tick. On the closing tick, shift[p][bit_idx] = ~data_d[p] for each pad p. Then go to SHIFT_HI.
  - SHIFT_HI: clk_q = 11 for 1 tick. On the closing tick, if bit_idx == 7 go to DONE, else increment bit_idx and go to SHIFT_LO.
  - DONE (1 cycle): pad[p] <= shift[p]; scan_done = 1; cpu_ack = served_cpu; then go to IDLE.
- Bit order: bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
- Timing: scan length from the start tick to entry into DONE = 18*CLK_DIV cycles. busy = 1 in LATCH and SHIFT states only.
- to_cpu <= pad[rs] every cycle, one-cycle latency. to_cpu reflects a new scan on the cycle after DONE.

Optional Feature:
JOYPAD_IRQ_EN
- Defined: in DONE, if {pad1,pad0} new != old, set irq. irq_clr = 1 clears irq. A set and a clear in the same cycle: set wins. irq holds until cleared.
- Undefined: irq tied to 0; irq_clr ignored; no compare logic.

Test Plan:
- CLK_DIV=4, auto_en=0, data_d=2'b11, pulse cpu_req -> busy for 72 cycles after the next tick, latch_q=11 for 8 cycles, 8 clk_q low pulses of 4 cycles each, scan_done and cpu_ack pulse once, to_cpu=00h.
- data_d[0] driven low only while bit_idx=0 and 3 (A, Start), data_d[1] low only at bit_idx=7 -> rs=0 gives to_cpu=09h, rs=1 gives to_cpu=80h one cycle after DONE.
- CLK_DIV=4, POLL_TICKS=30, auto_en=1, no cpu_req -> scan_done every 30 ticks (120 cycles), cpu_ack never asserted.
- cpu_req pulsed 3 times during one scan -> exactly one additional scan follows, cpu_ack pulses after each of the two scans.
- Assert rst_n=0 for 1 cycle mid-SHIFT with previous pad0=09h -> next cycle latch_q=00, clk_q=11, busy=0, to_cpu=00h; no scan_done.
- JOYPAD_IRQ_EN defined: scan changes pad0 00h->01h -> irq=1; irq_clr asserted in the same cycle as the next change-producing DONE -> irq stays 1.

Source files
------------

// File: rtl/nes_joypad_scan_ctrl.sv
// rtl/nes_joypad_scan_ctrl.sv - NES joypad scan sequencer with auto-poll/CPU request arbitration
// Optional button-change interrupt is built when JOYPAD_IRQ_EN is defined.
module nes_joypad_scan_ctrl #(
    parameter int CLK_DIV    = 200,
    parameter int POLL_TICKS = 2083
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] data_d,
    output logic [1:0] latch_q,
    output logic [1:0] clk_q,
    input  logic       auto_en,
    input  logic       cpu_req,
    output logic       cpu_ack,
    output logic       busy,
    output logic       scan_done,
    input  logic       rs,
    output logic [7:0] to_cpu,
    output logic       irq,
    input  logic       irq_clr
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int TW = (POLL_TICKS > 2) ? $clog2(POLL_TICKS) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] PER_MAX = TW'(POLL_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_start;

    logic [PW-1:0] r_pre;
    logic [TW-1:0] r_per;
    logic          w_tick;
    logic          w_per_wrap;
    logic          r_auto_pend;
    logic          r_cpu_pend;
    logic          r_served;
    logic          r_lcnt;
    logic [2:0]    r_bit;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [7:0]    r_shift0;
    logic [7:0]    r_shift1;
    logic [7:0]    r_pad0;
    logic [7:0]    r_pad1;
    logic [7:0]    w_pad0_nxt;
    logic [7:0]    w_pad1_nxt;
    logic [7:0]    r_to_cpu;
    logic          r_latch;
    logic          r_sclk;
    logic          r_busy;
    logic          r_done;
    logic          r_ack;

    assign w_tick     = (r_pre == PRE_MAX);
    assign w_per_wrap = auto_en && w_tick && (r_per == PER_MAX);
    // DONE forwards the fresh capture so to_cpu shows it on the very next cycle.
    assign w_pad0_nxt = (r_state == S_DONE) ? r_shift0 : r_pad0;
    assign w_pad1_nxt = (r_state == S_DONE) ? r_shift1 : r_pad1;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_tick && (r_auto_pend || r_cpu_pend)) begin
                    w_state_nxt = S_LATCH;
                    w_start     = 1'b1;
                end
            end
            S_LATCH:    if (w_tick && r_lcnt) w_state_nxt = S_SHIFT_LO;
            S_SHIFT_LO: if (w_tick) w_state_nxt = S_SHIFT_HI;
            S_SHIFT_HI: if (w_tick) w_state_nxt = (r_bit == 3'd7) ? S_DONE : S_SHIFT_LO;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre       <= '0;
            r_per       <= '0;
            r_auto_pend <= 1'b0;
            r_cpu_pend  <= 1'b0;
            r_served    <= 1'b0;
            r_lcnt      <= 1'b0;
            r_bit       <= 3'd0;
            r_sync1     <= 2'b11;
            r_sync2     <= 2'b11;
            r_shift0    <= 8'h00;
            r_shift1    <= 8'h00;
            r_pad0      <= 8'h00;
            r_pad1      <= 8'h00;
            r_to_cpu    <= 8'h00;
            r_latch     <= 1'b0;
            r_sclk      <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ack       <= 1'b0;
        end else begin
            r_pre   <= w_tick ? '0 : r_pre + 1'b1;
            r_sync1 <= data_d;
            r_sync2 <= r_sync1;

            if (!auto_en)     r_per <= '0;
            else if (w_tick)  r_per <= (r_per == PER_MAX) ? '0 : r_per + 1'b1;

            // A request landing on the start cycle survives the clear.
            if (w_start)    r_auto_pend <= 1'b0;
            if (w_per_wrap) r_auto_pend <= 1'b1;
            if (w_start)    r_cpu_pend  <= 1'b0;
            if (cpu_req)    r_cpu_pend  <= 1'b1;

            if (w_start) begin
                r_bit    <= 3'd0;
                r_lcnt   <= 1'b0;
                r_served <= r_cpu_pend;
            end
            if (r_state == S_LATCH && w_tick) r_lcnt <= 1'b1;
            if (r_state == S_SHIFT_LO && w_tick) begin
                r_shift0[r_bit] <= ~r_sync2[0];
                r_shift1[r_bit] <= ~r_sync2[1];
            end
            if (r_state == S_SHIFT_HI && w_tick && r_bit != 3'd7) r_bit <= r_bit + 3'd1;

            r_pad0   <= w_pad0_nxt;
            r_pad1   <= w_pad1_nxt;
            r_to_cpu <= rs ? w_pad1_nxt : w_pad0_nxt;

            r_latch <= (w_state_nxt == S_LATCH);
            r_sclk  <= (w_state_nxt != S_SHIFT_LO);
            r_busy  <= (w_state_nxt == S_LATCH) || (w_state_nxt == S_SHIFT_LO) ||
                       (w_state_nxt == S_SHIFT_HI);
            r_done  <= (w_state_nxt == S_DONE);
            r_ack   <= (w_state_nxt == S_DONE) && r_served;
        end
    end

    assign latch_q   = {2{r_latch}};
    assign clk_q     = {2{r_sclk}};
    assign busy      = r_busy;
    assign scan_done = r_done;
    assign cpu_ack   = r_ack;
    assign to_cpu    = r_to_cpu;

`ifdef JOYPAD_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_irq <= 1'b0;
        else if (r_state == S_DONE && {r_shift1, r_shift0} != {r_pad1, r_pad0})
            r_irq <= 1'b1;
        else if (irq_clr)
            r_irq <= 1'b0;
    end

    assign irq = r_irq;
`else
    logic w_unused_irq_clr;
    assign w_unused_irq_clr = irq_clr;
    assign irq              = 1'b0;
`endif

endmodule
